// File: rtl/bira_repair_engine.sv
// Built-in redundancy analysis: allocates spare rows/columns over an MBIST fault list.
// Optional must-repair pre-pass in ANALYZE is enabled with `define BIRA_MUST_REPAIR_EN.
module bira_repair_engine #(
  parameter int MAX_ROWS   = 16,
  parameter int MAX_COLS   = 16,
  parameter int MAX_FAULTS = 8,
  parameter int SPARE_ROWS = 4,
  parameter int SPARE_COLS = 4,
  localparam int RW  = $clog2(MAX_ROWS),
  localparam int CW  = $clog2(MAX_COLS),
  localparam int EW  = RW + CW + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_bira,
  input  logic [3:0]               fault_count,
  input  logic [MAX_FAULTS*EW-1:0] fault_list,
  output logic                     bira_done,
  output logic                     bira_success,
  output logic [MAX_ROWS-1:0]      row_repair_sig,
  output logic [MAX_COLS-1:0]      col_repair_sig
);

  localparam int RCW  = RW + CW;
  localparam int CNTW = $clog2(MAX_FAULTS + 1);
  localparam int IW   = (MAX_FAULTS > 1) ? $clog2(MAX_FAULTS) : 1;
  localparam int RUW  = $clog2(SPARE_ROWS + 1);
  localparam int CUW  = $clog2(SPARE_COLS + 1);

  typedef enum logic [1:0] {IDLE, ANALYZE, ALLOC, DONE} state_t;

  state_t                   state_q, state_n;
  logic [IW-1:0]            idx_q, idx_n;
  logic [CNTW-1:0]          cnt_q, cnt_n;
  logic [MAX_FAULTS*RCW-1:0] list_q, list_n;
  logic [MAX_ROWS-1:0]      rsig_n;
  logic [MAX_COLS-1:0]      csig_n;
  logic [RUW-1:0]           ru_q, ru_n;
  logic [CUW-1:0]           cu_q, cu_n;
  logic                     fail_q, fail_n;
  logic                     done_n, succ_n;
  logic [RW-1:0]            erow;
  logic [CW-1:0]            ecol;
  logic [2*MAX_FAULTS-1:0]  unused_type;

  // Only {row, col} is kept; fault_type bits are discarded at the port.
  for (genvar g = 0; g < MAX_FAULTS; g++) begin : g_type
    assign unused_type[2*g +: 2] = fault_list[g*EW +: 2];
  end

  assign erow = list_q[int'(idx_q)*RCW + CW +: RW];
  assign ecol = list_q[int'(idx_q)*RCW +: CW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      list_q         <= '0;
      row_repair_sig <= '0;
      col_repair_sig <= '0;
      ru_q           <= '0;
      cu_q           <= '0;
      fail_q         <= 1'b0;
      bira_done      <= 1'b0;
      bira_success   <= 1'b0;
    end else begin
      state_q        <= state_n;
      idx_q          <= idx_n;
      cnt_q          <= cnt_n;
      list_q         <= list_n;
      row_repair_sig <= rsig_n;
      col_repair_sig <= csig_n;
      ru_q           <= ru_n;
      cu_q           <= cu_n;
      fail_q         <= fail_n;
      bira_done      <= done_n;
      bira_success   <= succ_n;
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    list_n  = list_q;
    rsig_n  = row_repair_sig;
    csig_n  = col_repair_sig;
    ru_n    = ru_q;
    cu_n    = cu_q;
    fail_n  = fail_q;
    done_n  = 1'b0;
    succ_n  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          done_n = 1'b1;
          succ_n = !fail_q;
        end
        if (start_bira) begin
          for (int i = 0; i < MAX_FAULTS; i++)
            list_n[i*RCW +: RCW] = fault_list[i*EW + 2 +: RCW];
          cnt_n   = (int'(fault_count) > MAX_FAULTS) ? CNTW'(MAX_FAULTS) : CNTW'(fault_count);
          rsig_n  = '0;
          csig_n  = '0;
          ru_n    = '0;
          cu_n    = '0;
          fail_n  = 1'b0;
          done_n  = 1'b0;
          succ_n  = 1'b0;
          state_n = ANALYZE;
        end
      end
      ANALYZE: begin
`ifdef BIRA_MUST_REPAIR_EN
        // Row and column must-sets both come from the raw list, not from each other.
        for (int r = 0; r < MAX_ROWS; r++) begin : must_row
          int hits;
          hits = 0;
          for (int i = 0; i < MAX_FAULTS; i++)
            if (i < int'(cnt_q) && list_q[i*RCW + CW +: RW] == RW'(r)) hits++;
          if (hits > SPARE_COLS) begin
            if (ru_n < RUW'(SPARE_ROWS)) begin
              rsig_n[r] = 1'b1;
              ru_n      = ru_n + 1'b1;
            end else begin
              fail_n = 1'b1;
            end
          end
        end
        for (int c = 0; c < MAX_COLS; c++) begin : must_col
          int hits;
          hits = 0;
          for (int i = 0; i < MAX_FAULTS; i++)
            if (i < int'(cnt_q) && list_q[i*RCW +: CW] == CW'(c)) hits++;
          if (hits > SPARE_ROWS) begin
            if (cu_n < CUW'(SPARE_COLS)) begin
              csig_n[c] = 1'b1;
              cu_n      = cu_n + 1'b1;
            end else begin
              fail_n = 1'b1;
            end
          end
        end
`endif
        idx_n   = '0;
        state_n = ALLOC;
      end
      ALLOC: begin
        if (CNTW'(idx_q) < cnt_q && !(row_repair_sig[erow] || col_repair_sig[ecol])) begin
          if (ru_q < RUW'(SPARE_ROWS)) begin
            rsig_n[erow] = 1'b1;
            ru_n         = ru_q + 1'b1;
          end else if (cu_q < CUW'(SPARE_COLS)) begin
            csig_n[ecol] = 1'b1;
            cu_n         = cu_q + 1'b1;
          end else begin
            fail_n = 1'b1;
          end
        end
        if (idx_q == IW'(MAX_FAULTS - 1)) state_n = DONE;
        else idx_n = idx_q + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bira_repair_engine.sv
// Self-checking bench for bira_repair_engine: directed cases plus randomized lists vs. a list-walking model.
module tb_bira_repair_engine;
  localparam int EW  = 10;
  localparam int FLW = 8 * EW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_bira;
  logic [3:0]      fault_count;
  logic [FLW-1:0]  fault_list;
  logic            bira_done;
  logic            bira_success;
  logic [15:0]     row_repair_sig;
  logic [15:0]     col_repair_sig;

  int checks   = 0;
  int failures = 0;

  bira_repair_engine dut (
    .clk(clk), .rst(rst), .start_bira(start_bira), .fault_count(fault_count),
    .fault_list(fault_list), .bira_done(bira_done), .bira_success(bira_success),
    .row_repair_sig(row_repair_sig), .col_repair_sig(col_repair_sig)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input int r, input int c);
    return {4'(r), 4'(c), 2'($urandom)};
  endfunction

  // Reference: walk the list as the repair rules read, using plain arrays and counters.
  function automatic void model(input logic [FLW-1:0] fl, input int cnt_in,
                                output logic [15:0] rs, output logic [15:0] cs, output bit ok);
    int cnt, ru, cu, r, c;
    int rows[8];
    int cols[8];
    cnt = (cnt_in > 8) ? 8 : cnt_in;
    rs = '0; cs = '0; ru = 0; cu = 0; ok = 1;
    for (int i = 0; i < 8; i++) begin
      rows[i] = int'(fl[i*EW + 6 +: 4]);
      cols[i] = int'(fl[i*EW + 2 +: 4]);
    end
`ifdef BIRA_MUST_REPAIR_EN
    for (int line = 0; line < 16; line++) begin
      int n;
      n = 0;
      for (int i = 0; i < cnt; i++) if (rows[i] == line) n++;
      if (n > 4) begin
        if (ru < 4) begin rs[line] = 1'b1; ru++; end else ok = 0;
      end
    end
    for (int line = 0; line < 16; line++) begin
      int n;
      n = 0;
      for (int i = 0; i < cnt; i++) if (cols[i] == line) n++;
      if (n > 4) begin
        if (cu < 4) begin cs[line] = 1'b1; cu++; end else ok = 0;
      end
    end
`endif
    for (int i = 0; i < cnt; i++) begin
      r = rows[i]; c = cols[i];
      if (rs[r] || cs[c]) continue;
      if (ru < 4) begin rs[r] = 1'b1; ru++; end
      else if (cu < 4) begin cs[c] = 1'b1; cu++; end
      else ok = 0;
    end
  endfunction

  // Issues a start, scrambles the inputs afterwards, optionally re-pulses start at cycle poke.
  // lat = edges from the sampling edge until bira_done is seen (bounded).
  task automatic run(input logic [FLW-1:0] fl, input int cnt, input int poke,
                     output int lat, output bit cleared);
    @(posedge clk); #1;
    fault_list  = fl;
    fault_count = 4'(cnt);
    start_bira  = 1'b1;
    @(posedge clk); #1;
    start_bira  = 1'b0;
    cleared     = (bira_done === 1'b0);
    fault_list  = FLW'({$urandom, $urandom, $urandom});
    fault_count = 4'($urandom);
    lat = 0;
    while (bira_done !== 1'b1 && lat < 30) begin
      start_bira = (lat == poke);
      @(posedge clk); #1;
      lat++;
    end
    start_bira = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_bira = 1'b0; fault_count = '0; fault_list = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bira_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bira_done); end
    checks++; if (bira_success !== 1'b0) begin failures++; $display("FAIL reset_success got=%b want=0", bira_success); end
    checks++; if (row_repair_sig !== 16'h0) begin failures++; $display("FAIL reset_row got=%h want=0000", row_repair_sig); end
    checks++; if (col_repair_sig !== 16'h0) begin failures++; $display("FAIL reset_col got=%h want=0000", col_repair_sig); end
  endtask

  task automatic test_zero_count();
    int lat; bit cl;
    run({FLW{1'b1}}, 0, -1, lat, cl);
    checks++; if (lat !== 10) begin failures++; $display("FAIL zero_latency got=%0d want=10", lat); end
    checks++; if (bira_success !== 1'b1) begin failures++; $display("FAIL zero_success got=%b want=1", bira_success); end
    checks++; if ({row_repair_sig, col_repair_sig} !== 32'h0) begin failures++;
      $display("FAIL zero_sigs got=%h/%h want=0000/0000", row_repair_sig, col_repair_sig); end
  endtask

  task automatic test_directed();
    int lat; bit cl;
    logic [FLW-1:0] fl;
    fl = '0;
    fl[0*EW +: EW] = mk(3, 5); fl[1*EW +: EW] = mk(3, 9); fl[2*EW +: EW] = mk(7, 2);
    run(fl, 3, -1, lat, cl);
    checks++; if (row_repair_sig !== 16'h0088 || col_repair_sig !== 16'h0000 || bira_success !== 1'b1) begin failures++;
      $display("FAIL three_faults got=%h/%h/%b want=0088/0000/1", row_repair_sig, col_repair_sig, bira_success); end
    fl = '0;
    for (int i = 0; i < 6; i++) fl[i*EW +: EW] = mk(i, 10 + i);
    run(fl, 6, -1, lat, cl);
    checks++; if (cl !== 1'b1) begin failures++; $display("FAIL restart_clears_done got=%b want=1", cl); end
    checks++; if (row_repair_sig !== 16'h000F || col_repair_sig !== 16'hC000 || bira_success !== 1'b1) begin failures++;
      $display("FAIL six_faults got=%h/%h/%b want=000f/c000/1", row_repair_sig, col_repair_sig, bira_success); end
  endtask

  task automatic test_must_repair();
    int lat; bit cl;
    logic [FLW-1:0] fl;
    logic [15:0] er;
    fl = '0;
    for (int i = 0; i < 5; i++) fl[i*EW +: EW] = mk(i, 6);
`ifdef BIRA_MUST_REPAIR_EN
    er = 16'h0000;
`else
    er = 16'h000F;
`endif
    run(fl, 5, -1, lat, cl);
    checks++; if (lat !== 10) begin failures++; $display("FAIL must_latency got=%0d want=10", lat); end
    checks++; if (row_repair_sig !== er || col_repair_sig !== 16'h0040 || bira_success !== 1'b1) begin failures++;
      $display("FAIL col6 got=%h/%h/%b want=%h/0040/1", row_repair_sig, col_repair_sig, bira_success, er); end
  endtask

  task automatic test_start_mid_alloc();
    int lat; bit cl;
    logic [FLW-1:0] fl;
    fl = '0;
    fl[0*EW +: EW] = mk(3, 5); fl[1*EW +: EW] = mk(3, 9); fl[2*EW +: EW] = mk(7, 2);
    run(fl, 3, 4, lat, cl);
    checks++; if (lat !== 10) begin failures++; $display("FAIL poke_latency got=%0d want=10", lat); end
    checks++; if (row_repair_sig !== 16'h0088 || col_repair_sig !== 16'h0000 || bira_success !== 1'b1) begin failures++;
      $display("FAIL poke_result got=%h/%h/%b want=0088/0000/1", row_repair_sig, col_repair_sig, bira_success); end
  endtask

  task automatic test_reset_mid_alloc();
    int seen;
    logic [FLW-1:0] fl;
    fl = '0;
    for (int i = 0; i < 8; i++) fl[i*EW +: EW] = mk(i, i);
    @(posedge clk); #1;
    fault_list = fl; fault_count = 4'd8; start_bira = 1'b1;
    @(posedge clk); #1 start_bira = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bira_done, bira_success, row_repair_sig, col_repair_sig} !== 34'h0) begin failures++;
      $display("FAIL rst_mid_alloc got=%b/%b/%h/%h want=0/0/0000/0000", bira_done, bira_success, row_repair_sig, col_repair_sig); end
    rst = 1'b0;
    seen = 0;
    repeat (14) begin @(posedge clk); #1; if (bira_done === 1'b1) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rst_stays_idle got=%0d want=0", seen); end
  endtask

  task automatic test_clamp();
    int lat; bit cl;
    logic [FLW-1:0] fl;
    fl = '0;
    for (int i = 0; i < 8; i++) fl[i*EW +: EW] = mk(i, i);
    run(fl, 12, -1, lat, cl);
    checks++; if (lat !== 10) begin failures++; $display("FAIL clamp_latency got=%0d want=10", lat); end
    checks++; if (row_repair_sig !== 16'h000F || col_repair_sig !== 16'h00F0 || bira_success !== 1'b1) begin failures++;
      $display("FAIL clamp got=%h/%h/%b want=000f/00f0/1", row_repair_sig, col_repair_sig, bira_success); end
  endtask

  task automatic test_random();
    int lat, cnt; bit cl, ok;
    logic [FLW-1:0] fl;
    logic [15:0] er, ec;
    for (int t = 0; t < 40; t++) begin
      fl = '0;
      cnt = $urandom_range(0, 12);
      for (int i = 0; i < 8; i++) fl[i*EW +: EW] = mk($urandom_range(0, 7), $urandom_range(0, 7));
      if (t % 4 == 0) for (int i = 0; i < 8; i++) fl[i*EW + 2 +: 4] = 4'(t % 16);
      model(fl, cnt, er, ec, ok);
      run(fl, cnt, (t % 3 == 0) ? $urandom_range(0, 8) : -1, lat, cl);
      checks++; if (lat !== 10 || cl !== 1'b1) begin failures++;
        $display("FAIL rand_timing t=%0d got=%0d/%b want=10/1", t, lat, cl); end
      checks++; if (row_repair_sig !== er || col_repair_sig !== ec || bira_success !== ok) begin failures++;
        $display("FAIL rand_result t=%0d cnt=%0d got=%h/%h/%b want=%h/%h/%b", t, cnt,
                 row_repair_sig, col_repair_sig, bira_success, er, ec, ok); end
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit cl;
    logic [FLW-1:0] fl;
    fl = '0;
    fl[0*EW +: EW] = mk(9, 1);
    run(fl, 1, -1, lat, cl);
    checks++; if (row_repair_sig !== 16'h0200 || col_repair_sig !== 16'h0000) begin failures++;
      $display("FAIL b2b_first got=%h/%h want=0200/0000", row_repair_sig, col_repair_sig); end
    run('0, 0, -1, lat, cl);
    checks++; if (cl !== 1'b1 || lat !== 10 || {row_repair_sig, col_repair_sig} !== 32'h0 || bira_success !== 1'b1) begin failures++;
      $display("FAIL b2b_second got=%b/%0d/%h/%h/%b want=1/10/0000/0000/1", cl, lat, row_repair_sig, col_repair_sig, bira_success); end
  endtask

  initial begin
    test_reset();
    test_zero_count();
    test_directed();
    test_must_repair();
    test_start_mid_alloc();
    test_reset_mid_alloc();
    test_clamp();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bira_repair_engine.md
Name: bira_repair_engine

Overview:
- Built-in redundancy analysis (BIRA) engine for a 2D memory with spare rows and spare columns.
- Accepts a list of faulty (row, col) cells from MBIST and allocates spare rows/columns to cover every fault.
- Outputs one-hot-per-line repair signatures; the downstream BISR remapper sends repaired lines to spares in ascending index order.

Parameters:
- MAX_ROWS, 16, logical rows (row field width RW = clog2(MAX_ROWS))
- MAX_COLS, 16, logical columns (col field width CW = clog2(MAX_COLS))
- MAX_FAULTS, 8, fault list capacity
- SPARE_ROWS, 4, spare rows available
- SPARE_COLS, 4, spare columns available

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start_bira  in  1  start pulse, sampled only in IDLE
- fault_count  in  4  number of valid entries, clamped to MAX_FAULTS
- fault_list  in  MAX_FAULTS*(RW+CW+2)  packed records, entry i at bits [i*(RW+CW+2) +: RW+CW+2], laid out as {row[RW-1:0], col[CW-1:0], fault_type[1:0]}; fault_type is ignored
- bira_done  out  1  analysis complete (level)
- bira_success  out  1  all faults covered; valid while bira_done=1
- row_repair_sig  out  MAX_ROWS  bit r=1: row r replaced by a spare row
- col_repair_sig  out  MAX_COLS  bit c=1: column c replaced by a spare column

Behaviour:
- Reset:
  - All outputs 0, state IDLE, used counters 0.
  - Reset during any state aborts the analysis and returns to IDLE next edge.
- States: IDLE, ANALYZE, ALLOC, DONE.
- IDLE:
  - On start_bira=1: latch fault_list and min(fault_count, MAX_FAULTS).
  - Clear both signatures, both used counters, the fail flag and bira_done.
  - Go to ANALYZE.
- ANALYZE (1 cycle): must-repair phase; see Optional Feature. Then go to ALLOC with index i=0.
- ALLOC (exactly MAX_FAULTS cycles, i = 0..MAX_FAULTS-1), one entry per cycle. Entries with i >= latched count take the cycle but do nothing. For a valid entry:
  - Already covered (row_repair_sig[row] or col_repair_sig[col] set): skip.
  - Else if rows_used < SPARE_ROWS: set row bit, rows_used++.
  - Else if cols_used < SPARE_COLS: set col bit, cols_used++.
  - Else: set fail flag.
  - Signature updates in cycle i are visible to entry i+1.
- DONE:
  - bira_done=1 and bira_success = !fail.
  - Signatures held until the next accepted start.
  - A new start_bira re-enters ANALYZE via the IDLE actions (DONE also accepts start).
- Latency: start sampled at edge k gives bira_done=1 after edge k+MAX_FAULTS+2 (10 cycles at defaults).
- start_bira while in ANALYZE or ALLOC is ignored.
- Duplicate list entries are counted individually and are covered naturally.
- fault_count=0 gives success=1 and all-zero signatures.
- Spare usage never exceeds SPARE_ROWS / SPARE_COLS.

Optional Feature:
- Macro: BIRA_MUST_REPAIR_EN.
- When defined, ANALYZE computes per-row and per-column entry counts over the valid entries:
  - Any row with count > SPARE_COLS is must-repaired with a spare row, lowest row index first, while rows_used < SPARE_ROWS.
  - Any column with count > SPARE_ROWS is must-repaired with a spare column, lowest index first, while cols_used < SPARE_COLS.
  - Both sets are computed from the original list in the same cycle.
  - A must-line that cannot receive a spare sets the fail flag.
- When undefined, ANALYZE is an idle cycle and allocation is greedy only. Latency is identical either way.

Test Plan:
- Reset asserted then released, no start -> bira_done=0, bira_success=0, row_repair_sig=0, col_repair_sig=0.
- fault_count=0, start pulse -> bira_done=1 exactly 10 cycles later, success=1, both signatures 0.
- Faults (3,5),(3,9),(7,2) -> row_repair_sig=0x0088, col_repair_sig=0, success=1.
- Faults (0,10),(1,11),(2,12),(3,13),(4,14),(5,15) -> row_repair_sig=0x000F, col_repair_sig=0xC000, success=1.
- Faults (0..4, col 6), 5 entries:
  - with BIRA_MUST_REPAIR_EN -> row_repair_sig=0, col_repair_sig=0x0040, success=1;
  - without it -> row_repair_sig=0x000F, col_repair_sig=0x0040, success=1.
- Analysis interruptions:
  - start_bira pulsed mid-ALLOC -> ignored, same result and latency.
  - rst asserted mid-ALLOC -> all outputs 0, IDLE.
  - fault_count=12 with 8 diagonal faults (i,i) -> clamped to 8, row_repair_sig=0x000F, col_repair_sig=0x00F0, success=1.
